// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fnd_pkg
// Description : Shared constants for the FND scan decoder: segment patterns,
//               digit codes, FSM state encoding and select helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fnd_pkg;

    // Active-low segment patterns on font[6:0] (g..a); dp is excluded.
    localparam logic [6:0] c_seg_0     = 7'h40;
    localparam logic [6:0] c_seg_1     = 7'h79;
    localparam logic [6:0] c_seg_2     = 7'h24;
    localparam logic [6:0] c_seg_3     = 7'h30;
    localparam logic [6:0] c_seg_4     = 7'h19;
    localparam logic [6:0] c_seg_5     = 7'h12;
    localparam logic [6:0] c_seg_6     = 7'h02;
    localparam logic [6:0] c_seg_7     = 7'h78;
    localparam logic [6:0] c_seg_8     = 7'h00;
    localparam logic [6:0] c_seg_9     = 7'h10;
    localparam logic [6:0] c_seg_blank = 7'h7F;

    localparam logic [3:0] c_code_blank   = 4'hE;
    localparam logic [3:0] c_code_invalid = 4'hF;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_hold   = 2'd2;

    function automatic logic f_sel_legal(input logic [3:0] comm);
        return ($countones(~comm) == 1);
    endfunction

    function automatic logic [1:0] f_sel_idx(input logic [3:0] comm);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!comm[i]) idx = i[1:0];
        end
        return idx;
    endfunction

    function automatic logic f_any_invalid(input logic [15:0] slots);
        logic err;
        err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (slots[i*4 +: 4] == c_code_invalid) err = 1'b1;
        end
        return err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_seg_decode.sv
`default_nettype none
// ============================================================================
// Module      : fnd_seg_decode
// Description : Maps an active-low 7-segment pattern to a 4-bit digit code.
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_seg_decode
    import fnd_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_code
);

    always_comb begin
        o_code = c_code_invalid;
        case (i_seg)
            c_seg_0:     o_code = 4'd0;
            c_seg_1:     o_code = 4'd1;
            c_seg_2:     o_code = 4'd2;
            c_seg_3:     o_code = 4'd3;
            c_seg_4:     o_code = 4'd4;
            c_seg_5:     o_code = 4'd5;
            c_seg_6:     o_code = 4'd6;
            c_seg_7:     o_code = 4'd7;
            c_seg_8:     o_code = 4'd8;
            c_seg_9:     o_code = 4'd9;
            c_seg_blank: o_code = c_code_blank;
            default:     o_code = c_code_invalid;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fnd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : fnd_decoder
// Description : Snoops a multiplexed 4-digit 7-segment scan bus and rebuilds
//               the displayed digits, publishing one frame per full sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_decoder
    import fnd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fnd_comm,
    input  logic [7:0]  fnd_font,
    output logic [15:0] o_digits,
    output logic [3:0]  o_dp,
    output logic        o_valid,
    output logic        o_frame_err,
    output logic        o_sel_err,
    output logic        o_stale
);

    localparam int c_set_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int c_to_w  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_set_w-1:0] c_set_last = c_set_w'(SETTLE_CYCLES - 1);
    localparam logic [c_to_w-1:0]  c_to_max   = c_to_w'(TIMEOUT_CYCLES);
    localparam logic [c_to_w-1:0]  c_to_pre   = c_to_w'(TIMEOUT_CYCLES - 1);

    logic [3:0]         r_comm;
    logic [7:0]         r_font;
    logic [11:0]        r_trk;
    logic [1:0]         r_state;
    logic [c_set_w-1:0] r_cnt;
    logic [c_to_w-1:0]  r_tcnt;
    logic [3:0]         r_seen;
    logic [15:0]        r_slots;
    logic [3:0]         r_slot_dp;
    logic               r_ill_d;

    logic               w_idle;
    logic               w_legal;
    logic               w_illegal;
    logic [11:0]        w_cur;
    logic               w_changed;
    logic [1:0]         w_idx;
    logic [3:0]         w_code;
    logic [c_set_w-1:0] w_cnt_nxt;
    logic               w_capture;

    fnd_seg_decode u_seg_decode (
        .i_seg  (r_font[6:0]),
        .o_code (w_code)
    );

    always_comb begin
        w_idle    = (r_comm == 4'hF);
        w_legal   = f_sel_legal(r_comm);
        w_illegal = !w_idle && !w_legal;
        w_cur     = {r_comm, r_font};
        w_changed = (w_cur != r_trk);
        w_idx     = f_sel_idx(r_comm);
        w_cnt_nxt = r_cnt + 1'b1;
        // The entry cycle counts as the first settled cycle.
        w_capture = (r_state == c_st_settle) && !w_changed && (w_cnt_nxt >= c_set_last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_comm      <= 4'hF;
            r_font      <= 8'hFF;
            r_trk       <= {4'hF, 8'hFF};
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_tcnt      <= '0;
            r_seen      <= 4'h0;
            r_slots     <= {4{c_code_blank}};
            r_slot_dp   <= 4'h0;
            r_ill_d     <= 1'b0;
            o_digits    <= {4{c_code_blank}};
            o_dp        <= 4'h0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_sel_err   <= 1'b0;
            o_stale     <= 1'b0;
        end else begin
            r_comm    <= fnd_comm;
            r_font    <= fnd_font;
            r_ill_d   <= w_illegal;
            o_sel_err <= w_illegal && !r_ill_d;
            o_valid   <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_legal) begin
                        r_state <= c_st_settle;
                        r_cnt   <= '0;
                        r_trk   <= w_cur;
                    end
                end
                c_st_settle: begin
                    if (w_changed) begin
                        r_trk   <= w_cur;
                        r_cnt   <= '0;
                        r_state <= w_legal ? c_st_settle : c_st_idle;
                    end else if (w_capture) begin
                        r_state <= c_st_hold;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                c_st_hold: begin
                    if (w_changed) begin
                        r_trk   <= w_cur;
                        r_cnt   <= '0;
                        r_state <= w_legal ? c_st_settle : c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            if (w_capture) begin
                r_slots[{w_idx, 2'b00} +: 4] <= w_code;
                r_slot_dp[w_idx]             <= ~r_font[7];
                r_seen[w_idx]                <= 1'b1;
            end

            // A capture never lands in the cycle after the fourth one, so
            // publishing here cannot race a slot update.
            if (&r_seen) begin
                o_digits    <= r_slots;
                o_dp        <= r_slot_dp;
                o_frame_err <= f_any_invalid(r_slots);
                o_valid     <= 1'b1;
                o_stale     <= 1'b0;
                r_seen      <= 4'h0;
            end

            if (w_legal) begin
                r_tcnt <= '0;
            end else begin
                if (r_tcnt != c_to_max) r_tcnt <= r_tcnt + 1'b1;
                if (r_tcnt == c_to_pre) begin
                    o_stale <= 1'b1;
                    r_seen  <= 4'h0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fnd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fnd_decoder
// Description : Scoreboard bench for fnd_decoder scan-bus reconstruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fnd_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 50;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fnd_comm;
    logic [7:0]  fnd_font;
    logic [15:0] o_digits;
    logic [3:0]  o_dp;
    logic        o_valid;
    logic        o_frame_err;
    logic        o_sel_err;
    logic        o_stale;

    exp_t q[$];
    exp_t r_exp;
    int   checks  = 0;
    int   errors  = 0;
    int   n_valid = 0;
    int   n_sel   = 0;
    logic [7:0] font_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    fnd_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fnd_comm    (fnd_comm),
        .fnd_font    (fnd_font),
        .o_digits    (o_digits),
        .o_dp        (o_dp),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_sel_err   (o_sel_err),
        .o_stale     (o_stale)
    );

    always #5 clk = ~clk;

    // Scoreboard: every published frame is matched against the oldest expectation.
    always @(negedge clk) begin
        if (o_sel_err) n_sel++;
        if (o_valid) begin
            n_valid++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got digits=%h dp=%b, required no frame", o_digits, o_dp);
            end else begin
                r_exp = q.pop_front();
                if (o_digits !== r_exp.digits) begin
                    errors++;
                    $display("FAIL frame_digits: got %h required %h", o_digits, r_exp.digits);
                end
                checks++;
                if (o_dp !== r_exp.dp) begin
                    errors++;
                    $display("FAIL frame_dp: got %b required %b", o_dp, r_exp.dp);
                end
                checks++;
                if (o_frame_err !== r_exp.err) begin
                    errors++;
                    $display("FAIL frame_err: got %b required %b", o_frame_err, r_exp.err);
                end
            end
        end
    end

    function automatic exp_t mk_exp(input logic [15:0] d, input logic [3:0] dp, input logic err);
        exp_t e;
        e.digits = d;
        e.dp     = dp;
        e.err    = err;
        return e;
    endfunction

    function automatic logic [7:0] fnt(input int d, input logic dp_lit);
        logic [7:0] f;
        f = font_tab[d];
        if (dp_lit) f[7] = 1'b0;
        return f;
    endfunction

    // Called at a falling edge; idx < 0 releases the bus to all-off.
    task automatic drive(input int idx, input logic [7:0] font, input int cyc);
        logic [3:0] one;
        one      = 4'b0001;
        fnd_comm = (idx < 0) ? 4'hF : ~(one << idx);
        fnd_font = font;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic sweep(input logic [7:0] f3, input logic [7:0] f2,
                         input logic [7:0] f1, input logic [7:0] f0, input int cyc);
        drive(3, f3, cyc);
        drive(2, f2, cyc);
        drive(1, f1, cyc);
        drive(0, f0, cyc);
        drive(-1, 8'hFF, 8);
    endtask

    task automatic test_reset();
        checks++; if (o_digits !== 16'hEEEE) begin errors++; $display("FAIL reset_digits: got %h required EEEE", o_digits); end
        checks++; if (o_dp !== 4'h0) begin errors++; $display("FAIL reset_dp: got %b required 0000", o_dp); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", o_valid); end
        checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b required 0", o_frame_err); end
        checks++; if (o_sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %b required 0", o_sel_err); end
        checks++; if (o_stale !== 1'b0) begin errors++; $display("FAIL reset_stale: got %b required 0", o_stale); end
    endtask

    task automatic test_basic_sweep();
        int v0;
        v0 = n_valid;
        q.push_back(mk_exp(16'h1234, 4'b0100, 1'b0));
        sweep(fnt(1, 0), fnt(2, 1), fnt(3, 0), fnt(4, 0), 20);
        checks++;
        if (n_valid - v0 != 1) begin
            errors++; $display("FAIL basic_valid_count: got %0d required 1", n_valid - v0); q.delete();
        end
    endtask

    task automatic test_settle_boundary();
        int v0;
        v0 = n_valid;
        q.push_back(mk_exp(16'h5678, 4'b0000, 1'b0));
        sweep(fnt(5, 0), fnt(6, 0), fnt(7, 0), fnt(8, 0), SETTLE);
        checks++;
        if (n_valid - v0 != 1) begin
            errors++; $display("FAIL boundary_valid_count: got %0d required 1", n_valid - v0); q.delete();
        end
    endtask

    task automatic test_short_hold();
        int v0;
        v0 = n_valid;
        drive(3, fnt(9, 0), 20);
        drive(2, fnt(8, 0), 20);
        drive(1, fnt(7, 0), 20);
        drive(0, fnt(1, 0), SETTLE - 1);
        drive(-1, 8'hFF, 10);
        checks++;
        if (n_valid - v0 != 0) begin
            errors++; $display("FAIL short_hold_no_valid: got %0d required 0", n_valid - v0);
        end
        checks++;
        if (o_digits !== 16'h5678) begin
            errors++; $display("FAIL short_hold_digits: got %h required 5678", o_digits);
        end
        q.push_back(mk_exp(16'h9870, 4'b0000, 1'b0));
        drive(0, fnt(0, 0), 20);
        drive(-1, 8'hFF, 8);
        checks++;
        if (n_valid - v0 != 1) begin
            errors++; $display("FAIL short_hold_completion: got %0d required 1", n_valid - v0); q.delete();
        end
    endtask

    task automatic test_invalid_font();
        int v0;
        v0 = n_valid;
        q.push_back(mk_exp(16'h34F6, 4'b0000, 1'b1));
        sweep(fnt(3, 0), fnt(4, 0), 8'hA5, fnt(6, 0), 20);
        checks++;
        if (n_valid - v0 != 1) begin
            errors++; $display("FAIL invalid_valid_count: got %0d required 1", n_valid - v0); q.delete();
        end
    endtask

    task automatic test_sel_err();
        int v0;
        int s0;
        v0 = n_valid;
        s0 = n_sel;
        q.push_back(mk_exp(16'h2468, 4'b0001, 1'b0));
        drive(3, fnt(2, 0), 20);
        drive(2, fnt(4, 0), 20);
        fnd_comm = 4'b1100;
        fnd_font = fnt(5, 0);
        repeat (5) @(negedge clk);
        drive(1, fnt(6, 0), 20);
        drive(0, fnt(8, 1), 20);
        drive(-1, 8'hFF, 8);
        checks++;
        if (n_sel - s0 != 1) begin
            errors++; $display("FAIL sel_err_pulses: got %0d required 1", n_sel - s0);
        end
        checks++;
        if (n_valid - v0 != 1) begin
            errors++; $display("FAIL sel_err_resume_valid: got %0d required 1", n_valid - v0); q.delete();
        end
    endtask

    task automatic test_timeout();
        int v0;
        drive(0, fnt(1, 0), 2);
        drive(-1, 8'hFF, TIMEOUT - 5);
        checks++;
        if (o_stale !== 1'b0) begin
            errors++; $display("FAIL stale_early: got %b required 0", o_stale);
        end
        drive(-1, 8'hFF, 10);
        checks++;
        if (o_stale !== 1'b1) begin
            errors++; $display("FAIL stale_set: got %b required 1", o_stale);
        end
        checks++;
        if (o_digits !== 16'h2468) begin
            errors++; $display("FAIL stale_digits_held: got %h required 2468", o_digits);
        end
        v0 = n_valid;
        q.push_back(mk_exp(16'h1357, 4'b0000, 1'b0));
        drive(3, fnt(1, 0), 20);
        checks++;
        if (o_stale !== 1'b1) begin
            errors++; $display("FAIL stale_kept_on_select: got %b required 1", o_stale);
        end
        drive(2, fnt(3, 0), 20);
        drive(1, fnt(5, 0), 20);
        drive(0, fnt(7, 0), 20);
        drive(-1, 8'hFF, 8);
        checks++;
        if (n_valid - v0 != 1) begin
            errors++; $display("FAIL stale_sweep_valid: got %0d required 1", n_valid - v0); q.delete();
        end
        checks++;
        if (o_stale !== 1'b0) begin
            errors++; $display("FAIL stale_cleared: got %b required 0", o_stale);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        drive(3, fnt(9, 0), 20);
        drive(2, fnt(8, 0), 20);
        fnd_comm = 4'hF;
        fnd_font = 8'hFF;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (o_digits !== 16'hEEEE) begin
            errors++; $display("FAIL reset_mid_digits: got %h required EEEE", o_digits);
        end
        v0 = n_valid;
        q.push_back(mk_exp(16'h4321, 4'b0000, 1'b0));
        drive(1, fnt(2, 0), 20);
        drive(0, fnt(1, 0), 20);
        drive(-1, 8'hFF, 4);
        checks++;
        if (n_valid - v0 != 0) begin
            errors++; $display("FAIL reset_mid_partial_valid: got %0d required 0", n_valid - v0);
        end
        sweep(fnt(4, 0), fnt(3, 0), fnt(2, 0), fnt(1, 0), 20);
        checks++;
        if (n_valid - v0 != 1) begin
            errors++; $display("FAIL reset_mid_valid_count: got %0d required 1", n_valid - v0); q.delete();
        end
    endtask

    initial begin
        reset    = 1'b1;
        fnd_comm = 4'hF;
        fnd_font = 8'hFF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_basic_sweep();
        test_settle_boundary();
        test_short_hold();
        test_invalid_font();
        test_sel_err();
        test_timeout();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
